// File: rtl/conf_int_mul_pipe__arch_agnos.sv
// Pipelined configurable-precision signed multiplier with valid/ready flow control.
// Define CONF_MUL_SAT_EN to clamp out-of-range results; otherwise results wrap.
module conf_int_mul_pipe__arch_agnos #(
   parameter int A_WIDTH     = 24,
   parameter int B_WIDTH     = 13,
   parameter int A_KEEP      = 16,
   parameter int B_KEEP      = 10,
   parameter int P_WIDTH     = 32,
   parameter int SH_WIDTH    = 6,
   parameter int PIPE_STAGES = 2
) (
   input  logic                clk,
   input  logic                rstP,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [A_WIDTH-1:0]  a,
   input  logic [B_WIDTH-1:0]  b,
   input  logic                apx_en,
   input  logic [SH_WIDTH-1:0] out_shift,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [P_WIDTH-1:0]  p,
   output logic [15:0]         apx_count,
   input  logic                apx_count_clr
);
   localparam int PW = A_WIDTH + B_WIDTH;
   localparam int XW = (PW > P_WIDTH) ? PW : P_WIDTH;
   localparam logic [A_WIDTH-1:0] A_MASK = {A_WIDTH{1'b1}} << (A_WIDTH - A_KEEP);
   localparam logic [B_WIDTH-1:0] B_MASK = {B_WIDTH{1'b1}} << (B_WIDTH - B_KEEP);

   logic                                   stall;
   logic                                   accept;
   logic [PIPE_STAGES:1]                   vld_pipe;
   logic signed [A_WIDTH-1:0]              s1_a;
   logic signed [B_WIDTH-1:0]              s1_b;
   logic [SH_WIDTH-1:0]                    s1_sh;
   logic [PIPE_STAGES:2][P_WIDTH-1:0]      p_pipe;
   logic signed [PW-1:0]                   prod;
   logic signed [PW-1:0]                   shd;
   logic signed [XW-1:0]                   ext;
   logic [P_WIDTH-1:0]                     nar;

   assign out_valid = vld_pipe[PIPE_STAGES];
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;
   assign accept    = in_valid && in_ready;
   assign p         = p_pipe[PIPE_STAGES];

   assign prod = s1_a * s1_b;

   // Shifts past the product width collapse to pure sign fill.
   always_comb begin
      shd = prod >>> s1_sh;
      if (int'(s1_sh) >= PW) shd = {PW{prod[PW-1]}};
   end

   assign ext = XW'(shd);

   always_comb begin
      nar = ext[P_WIDTH-1:0];
`ifdef CONF_MUL_SAT_EN
      if (!((&ext[XW-1:P_WIDTH-1]) || !(|ext[XW-1:P_WIDTH-1])))
         nar = ext[XW-1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
`endif
   end

   // One global enable: a stall freezes every stage, bubbles included.
   always_ff @(posedge clk) begin
      if (rstP) begin
         vld_pipe <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_sh    <= '0;
         p_pipe   <= '0;
      end else if (!stall) begin
         vld_pipe <= {vld_pipe[PIPE_STAGES-1:1], accept};
         if (accept) begin
            s1_a  <= apx_en ? (a & A_MASK) : a;
            s1_b  <= apx_en ? (b & B_MASK) : b;
            s1_sh <= out_shift;
         end
         if (vld_pipe[1]) p_pipe[2] <= nar;
         for (int k = 3; k <= PIPE_STAGES; k++)
            if (vld_pipe[k-1]) p_pipe[k] <= p_pipe[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rstP || apx_count_clr)
         apx_count <= '0;
      else if (accept && apx_en && apx_count != 16'hFFFF)
         apx_count <= apx_count + 16'd1;
   end
endmodule

// File: tb/tb_conf_int_mul_pipe__arch_agnos.sv
// Self-checking bench for conf_int_mul_pipe__arch_agnos: vector table, scoreboard,
// backpressure, reset and counter sequences.
module tb_conf_int_mul_pipe__arch_agnos;
   logic        clk = 0;
   logic        rstP;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] a;
   logic [12:0] b;
   logic        apx_en;
   logic [5:0]  out_shift;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;
   logic [15:0] apx_count;
   logic        apx_count_clr;

   int          errors = 0;
   int          checks = 0;
   int          exp_cnt = 0;
   int          n_pop = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   conf_int_mul_pipe__arch_agnos dut (
      .clk(clk), .rstP(rstP), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .apx_en(apx_en), .out_shift(out_shift),
      .out_valid(out_valid), .out_ready(out_ready), .p(p),
      .apx_count(apx_count), .apx_count_clr(apx_count_clr)
   );

   typedef struct {
      logic [23:0] a;
      logic [12:0] b;
      logic        apx;
      logic [5:0]  sh;
      logic [31:0] p;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [23:0] ia, input logic [12:0] ib,
                                         input logic iapx, input logic [5:0] ish);
      logic [23:0] ga;
      logic [12:0] gb;
      longint      pr;
      ga = iapx ? {ia[23:8], 8'h00} : ia;
      gb = iapx ? {ib[12:3], 3'h0} : ib;
      pr = longint'($signed(ga)) * longint'($signed(gb));
      if (int'(ish) >= 37) pr = (pr < 0) ? -64'sd1 : 64'sd0;
      else pr = pr >>> ish;
`ifdef CONF_MUL_SAT_EN
      if (pr > 64'sd2147483647) pr = 64'sd2147483647;
      if (pr < -64'sd2147483648) pr = -64'sd2147483648;
`endif
      return pr[31:0];
   endfunction

   // One cycle: drive at negedge, resolve both handshakes, advance to next negedge.
   task automatic cyc(input logic iv, input logic [23:0] ia, input logic [12:0] ib,
                      input logic iapx, input logic [5:0] ish, input logic [31:0] iexp,
                      input logic ordy, input logic rst, input logic clr,
                      output logic acc, output logic ir, output logic ov, output logic [31:0] pv);
      logic [31:0] e;
      in_valid = iv; a = ia; b = ib; apx_en = iapx; out_shift = ish;
      out_ready = ordy; rstP = rst; apx_count_clr = clr;
      #1;
      acc = 1'b0; ir = in_ready; ov = out_valid; pv = p;
      if (rst) begin
         sb_q.delete();
         exp_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            n_pop++;
            if (sb_q.size() == 0) chk("unexpected_out", {32'h0, p}, 64'hDEAD);
            else begin
               e = sb_q.pop_front();
               chk("sb_p", {32'h0, p}, {32'h0, e});
            end
         end
         acc = in_valid && in_ready;
         if (acc) sb_q.push_back(iexp);
         if (clr) exp_cnt = 0;
         else if (acc && iapx && exp_cnt != 65535) exp_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic idle(output logic ov);
      logic acc, ir;
      logic [31:0] pv;
      cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc, ir, ov, pv);
   endtask

   task automatic drain(input string name);
      logic ov;
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) idle(ov);
      chk(name, 64'(sb_q.size()), 64'd0);
   endtask

   vec_t        tbl[8];
   logic        acc, ir, ov;
   logic [31:0] pv, held;
   logic [23:0] sa[6];
   logic [12:0] sbv[6];
   logic [5:0]  ssh[6];
   int          idx, pop0;

   initial begin
      tbl[0] = '{24'd256,    13'd3,    1'b0, 6'd0,  32'd768};
      tbl[1] = '{24'h0001FF, 13'h000F, 1'b1, 6'd0,  32'd2048};
      tbl[2] = '{-24'sd3,    13'd5,    1'b0, 6'd0,  32'hFFFFFFF1};
      tbl[3] = '{24'h7FFFFF, 13'd4095, 1'b0, 6'd4,  32'h7FF7FF00};
      tbl[4] = '{24'h7FFFFF, 13'd4095, 1'b0, 6'd40, 32'h0};
`ifdef CONF_MUL_SAT_EN
      tbl[5] = '{24'h7FFFFF, 13'd4095, 1'b0, 6'd0,  32'h7FFFFFFF};
`else
      tbl[5] = '{24'h7FFFFF, 13'd4095, 1'b0, 6'd0,  32'hFF7FF001};
`endif
      tbl[6] = '{-24'sd3,    13'd5,    1'b0, 6'd1,  32'hFFFFFFF8};
      tbl[7] = '{-24'sd3,    13'd5,    1'b0, 6'd63, 32'hFFFFFFFF};

      in_valid = 0; a = 0; b = 0; apx_en = 0; out_shift = 0;
      out_ready = 1; apx_count_clr = 0; rstP = 1;
      repeat (3) @(negedge clk);
      rstP = 0;
      #1;
      chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
      chk("rst_p", {32'h0, p}, 64'd0);
      chk("rst_apx_count", {48'h0, apx_count}, 64'd0);
      chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
      @(negedge clk);

      // Latency: accept at edge N, out_valid only after edge N+1.
      cyc(1'b1, 24'd256, 13'd3, 1'b0, 6'd0, 32'd768, 1'b1, 1'b0, 1'b0, acc, ir, ov, pv);
      chk("lat_accept", {63'h0, acc}, 64'd1);
      idle(ov);
      chk("lat_cycle1", {63'h0, ov}, 64'd0);
      idle(ov);
      chk("lat_cycle2", {63'h0, ov}, 64'd1);
      chk("acc_count0", {48'h0, apx_count}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].apx, tbl[i].sh, tbl[i].p, 1'b1, 1'b0, 1'b0,
             acc, ir, ov, pv);
         drain("tbl_drain");
         chk("tbl_apx_count", {48'h0, apx_count}, 64'(exp_cnt));
      end
      chk("apx_count_one", {48'h0, apx_count}, 64'd1);

      // Backpressure: 6 back-to-back ops, out_ready low for cycles 3..5.
      for (int i = 0; i < 6; i++) begin
         sa[i] = 24'($urandom); sbv[i] = 13'($urandom); ssh[i] = 6'($urandom_range(0, 12));
      end
      idx = 0; pop0 = n_pop; held = '0;
      for (int t = 0; t < 30 && (idx < 6 || t < 6); t++) begin
         if (idx < 6)
            cyc(1'b1, sa[idx], sbv[idx], 1'b0, ssh[idx], model(sa[idx], sbv[idx], 1'b0, ssh[idx]),
                !(t >= 3 && t <= 5), 1'b0, 1'b0, acc, ir, ov, pv);
         else
            cyc(1'b0, '0, '0, 1'b0, '0, '0, !(t >= 3 && t <= 5), 1'b0, 1'b0, acc, ir, ov, pv);
         if (t == 3) held = pv;
         if (t >= 3 && t <= 5) begin
            chk("stall_in_ready", {63'h0, ir}, 64'd0);
            chk("stall_p_stable", {32'h0, pv}, {32'h0, held});
         end
         if (acc) idx++;
      end
      drain("bp_drain");
      chk("bp_count", 64'(n_pop - pop0), 64'd6);

      // Reset with operations in flight discards them.
      cyc(1'b1, 24'h123456, 13'h0ABC, 1'b1, 6'd0, model(24'h123456, 13'h0ABC, 1'b1, 6'd0),
          1'b1, 1'b0, 1'b0, acc, ir, ov, pv);
      cyc(1'b1, 24'h654321, 13'h0123, 1'b1, 6'd0, 32'h0, 1'b1, 1'b1, 1'b0, acc, ir, ov, pv);
      for (int i = 0; i < 5; i++) begin
         idle(ov);
         chk("rst_flight_ov", {63'h0, ov}, 64'd0);
      end
      chk("rst_flight_p", {32'h0, p}, 64'd0);
      chk("rst_flight_cnt", {48'h0, apx_count}, 64'd0);

      // Clear wins over a simultaneous increment.
      cyc(1'b1, 24'h000100, 13'h0008, 1'b1, 6'd0, model(24'h000100, 13'h0008, 1'b1, 6'd0),
          1'b1, 1'b0, 1'b0, acc, ir, ov, pv);
      cyc(1'b1, 24'h000200, 13'h0008, 1'b1, 6'd0, model(24'h000200, 13'h0008, 1'b1, 6'd0),
          1'b1, 1'b0, 1'b1, acc, ir, ov, pv);
      chk("clr_count", {48'h0, apx_count}, 64'd0);
      drain("clr_drain");

      // Saturation after 65540 approximate operations.
      for (int i = 0; i < 65540; i++) begin
         sa[0] = 24'($urandom); sbv[0] = 13'($urandom); ssh[0] = 6'($urandom);
         cyc(1'b1, sa[0], sbv[0], 1'b1, ssh[0], model(sa[0], sbv[0], 1'b1, ssh[0]),
             1'b1, 1'b0, 1'b0, acc, ir, ov, pv);
      end
      drain("sat_drain");
      chk("sat_count", {48'h0, apx_count}, 64'hFFFF);
      chk("sat_model", {48'h0, apx_count}, 64'(exp_cnt));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conf_int_mul_pipe__arch_agnos.md
# conf_int_mul_pipe__arch_agnos

Parametrised, pipelined, configurable-precision signed multiplier for the IDCT datapath. Each operation carries its own accurate/approximate mode and output-window shift. A valid/ready handshake on both sides replaces the fixed state/count0 sequencing, so the IDCT controller can stall the multiplier. A saturating counter records how many approximate operations were issued.

## Interface
Parameters:
- A_WIDTH, 24, width of signed operand a
- B_WIDTH, 13, width of signed operand b
- A_KEEP, 16, MSBs of a retained in approximate mode (1..A_WIDTH)
- B_KEEP, 10, MSBs of b retained in approximate mode (1..B_WIDTH)
- P_WIDTH, 32, output width
- SH_WIDTH, 6, width of out_shift
- PIPE_STAGES, 2, register stages from accept to output (2..4)

Ports:
- clk  in  1  clock; all logic on rising edge
- rstP  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept
- a  in  A_WIDTH  signed multiplicand
- b  in  B_WIDTH  signed multiplier
- apx_en  in  1  1 = approximate mode for this operation
- out_shift  in  SH_WIDTH  arithmetic right shift applied to the full product
- out_valid  out  1  p holds a result
- out_ready  in  1  consumer accepts p
- p  out  P_WIDTH  signed result
- apx_count  out  16  approximate operations accepted
- apx_count_clr  in  1  synchronous clear of apx_count

## Operation
- Accept when in_valid && in_ready. a, b, apx_en and out_shift are captured into stage 1.
- Operand gating at capture:
  - If apx_en=1, the low A_WIDTH-A_KEEP bits of a and the low B_WIDTH-B_KEEP bits of b are stored as 0.
  - If apx_en=0, the full operands are stored.
- Full product: signed, A_WIDTH+B_WIDTH bits (37 by default), never truncated before shifting.
- Shift: arithmetic right shift (floor) by out_shift. A shift of product width or more yields all sign bits (0 or -1).
- Narrowing to P_WIDTH follows the rule set in Configuration.
- The shifted result is registered in stage 2. Stages 3..PIPE_STAGES are pure delay, each with its own valid bit.
- Stall: stall = out_valid && !out_ready.
  - While stalled, every stage holds, and p, out_valid and apx_count are stable.
  - in_ready = !stall, combinational.
  - Bubbles are not collapsed.
- Ordering: results emerge strictly in acceptance order. There is no drop and no duplication.
- apx_count:
  - Increments on an accepted operation with apx_en=1.
  - Saturates at 16'hFFFF.
  - apx_count_clr has priority: if clear and increment occur in the same cycle, the count becomes 0.
- Reset: all valid bits 0, p=0, apx_count=0, in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight results.
  - out_valid is never raised for a result accepted before reset.

## Timing
- Latency: a result accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles from in_valid sampling to the out_valid handshake, with no stall.
- Throughput: one operation per cycle while out_ready=1.
- Each stall cycle adds exactly one cycle of latency to every in-flight operation.
- p is fully registered. Handshake paths are combinational only through in_ready = f(out_valid, out_ready).
- Critical path: stage-1 registers -> multiplier -> barrel shifter -> saturation -> stage-2 register.

## Configuration
- CONF_MUL_SAT_EN defined: a shifted product outside the signed P_WIDTH range clamps to 2^(P_WIDTH-1)-1 or -2^(P_WIDTH-1).
- CONF_MUL_SAT_EN undefined: the low P_WIDTH bits of the shifted product are output (two's-complement wrap). No clamp logic is synthesised.

## Test plan
- Accurate mode, PIPE_STAGES=2: a=256, b=3, apx_en=0, shift 0 -> p=768, out_valid 2 cycles after accept; apx_count stays 0.
- Approximate gating: a=24'h0001FF, b=13'h000F, apx_en=1, shift 0 -> operands gated to 256 and 8 -> p=2048; apx_count=1.
- Signed and shift:
  - a=-3, b=5, shift 0 -> p=32'hFFFFFFF1.
  - a=24'h7FFFFF, b=4095, shift 4 -> p=32'h7FF7FF00.
  - Same operands, shift 40 -> p=0.
- Overflow, same operands with shift 0:
  - CONF_MUL_SAT_EN defined -> p=32'h7FFFFFFF.
  - CONF_MUL_SAT_EN undefined -> p=32'hFF7FF001.
- Backpressure: issue a back-to-back stream of 6 operations and hold out_ready=0 for 3 cycles mid-stream.
  - in_ready=0 and p stable throughout the stall.
  - After release, all 6 results emerge in order with no loss.
- Reset/counter:
  - Assert rstP with 2 operations in flight -> out_valid never rises for them; p=0 and apx_count=0.
  - Assert apx_count_clr on the cycle of an apx accept -> apx_count=0.
  - Issue 65540 apx operations -> apx_count=16'hFFFF.
